// File: rtl/paddle_reader_pkg.sv
// Shared paddle definitions: FSM state encoding and paddle bounds common to the
// game logic and paddle_reader.
package paddle_reader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int unsigned PADDLE_WIDTH    = 31;
  localparam int unsigned POS_MIN_DEFAULT = 0;
  localparam int unsigned POS_MAX_DEFAULT = 256 - PADDLE_WIDTH;

endpackage

// File: rtl/paddle_reader_tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV into a one-cycle tick strobe;
// clr restarts the division so the first tick lands TICK_DIV cycles later.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/paddle_reader.sv
// paddle_reader: times the paddle RC recharge once per frame and commits a
// clamped 9-bit paddle position at vsync rise. Optional: PADDLE_FILTER_EN.
module paddle_reader
  import paddle_reader_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 64,
  parameter int unsigned DISCHARGE_TICKS = 16,
  parameter int unsigned COUNT_OFFSET    = 0,
  parameter int unsigned POS_MIN         = POS_MIN_DEFAULT,
  parameter int unsigned POS_MAX         = POS_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       pdl_n,
  output logic       pdl_discharge,
  output logic [8:0] paddle_pos,
  output logic       pos_valid,
  output logic       timeout
);

  localparam int unsigned DW      = (DISCHARGE_TICKS > 1) ? $clog2(DISCHARGE_TICKS) : 1;
  localparam logic [8:0]  POS_MID = 9'((POS_MIN + POS_MAX) / 2);

  state_t        state, state_n;
  logic          pdl_meta, pdl_s, vsync_d, frame_start, tick, tick_clr;
  logic          commit, abort, tmo_p, tmo_p_n;
  logic [8:0]    count, count_n, sample, sample_n, d, pos_next;
  logic [DW-1:0] dtick, dtick_n;
  int            d_int;

  assign frame_start = vsync & ~vsync_d;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_n  = state;
    count_n  = count;
    sample_n = sample;
    tmo_p_n  = tmo_p;
    dtick_n  = dtick;
    tick_clr = 1'b0;
    commit   = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: ;
      DISCHARGE: begin
        abort = frame_start;
        if (tick) begin
          if (dtick == DW'(DISCHARGE_TICKS - 1)) begin
            dtick_n = '0;
            count_n = '0;
            state_n = MEASURE;
          end else begin
            dtick_n = dtick + 1'b1;
          end
        end
      end
      MEASURE: begin
        abort = frame_start;
        if (tick) begin
          count_n = (count == '1) ? count : count + 1'b1;
          if (!pdl_s) begin
            sample_n = count_n;
            tmo_p_n  = 1'b0;
            state_n  = DONE;
          end else if (count_n == '1) begin
            sample_n = '1;
            tmo_p_n  = 1'b1;
            state_n  = DONE;
          end
        end
      end
      DONE: commit = frame_start;
    endcase
    // Every vsync rise (re)starts a discharge regardless of state; this also
    // covers the abort path and the DONE -> DISCHARGE commit path.
    if (frame_start) begin
      state_n  = DISCHARGE;
      dtick_n  = '0;
      tick_clr = 1'b1;
    end
  end

  always_comb begin
    d_int = int'(sample) - int'(COUNT_OFFSET);
    if (d_int < int'(POS_MIN))      d_int = int'(POS_MIN);
    else if (d_int > int'(POS_MAX)) d_int = int'(POS_MAX);
    d = 9'(d_int);
`ifdef PADDLE_FILTER_EN
    pos_next = 9'((11'(paddle_pos) * 11'd3 + 11'(d)) >> 2);
`else
    pos_next = d;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pdl_meta      <= 1'b1;
      pdl_s         <= 1'b1;
      vsync_d       <= 1'b0;
      count         <= '0;
      sample        <= '0;
      tmo_p         <= 1'b0;
      dtick         <= '0;
      pdl_discharge <= 1'b0;
      paddle_pos    <= POS_MID;
      pos_valid     <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_n;
      pdl_meta      <= pdl_n;
      pdl_s         <= pdl_meta;
      vsync_d       <= vsync;
      count         <= count_n;
      sample        <= sample_n;
      tmo_p         <= tmo_p_n;
      dtick         <= dtick_n;
      pdl_discharge <= (state_n == DISCHARGE);
      pos_valid     <= commit;
      if (commit) begin
        paddle_pos <= pos_next;
        timeout    <= tmo_p;
      end else if (abort) begin
        timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paddle_reader.sv
// Directed bench for paddle_reader with TICK_DIV=4, DISCHARGE_TICKS=2,
// COUNT_OFFSET=10; expected positions follow PADDLE_FILTER_EN if defined.
module tb_paddle_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       pdl_n = 1'b1;
  logic       pdl_discharge, pos_valid, timeout;
  logic [8:0] paddle_pos;

  int errors = 0;
  int checks = 0;
  int model_pos = 112;

  always #5 clk = ~clk;

  paddle_reader #(
    .TICK_DIV        (4),
    .DISCHARGE_TICKS (2),
    .COUNT_OFFSET    (10),
    .POS_MIN         (0),
    .POS_MAX         (225)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vsync         (vsync),
    .pdl_n         (pdl_n),
    .pdl_discharge (pdl_discharge),
    .paddle_pos    (paddle_pos),
    .pos_valid     (pos_valid),
    .timeout       (timeout)
  );

  function automatic int commit_model(input int prev, input int d);
`ifdef PADDLE_FILTER_EN
    return (3 * prev + d) / 4;
`else
    return d;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle N+1 after a one-cycle vsync pulse in cycle N.
  task automatic frame_rise();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
  endtask

  // Called in cycle N+1; returns discharge length and pos_valid high cycles.
  task automatic discharge_len(output int n, output int pv);
    n = 0;
    pv = 0;
    while (pdl_discharge === 1'b1 && n < 50) begin
      n++;
      if (pos_valid === 1'b1) pv++;
      step();
    end
  endtask

  // Called on the first MEASURE cycle; pdl_s is low at tick t and high at t-1.
  task automatic measure(input int t);
    repeat (4 * (t - 1)) step();
    pdl_n = 1'b0;
    repeat (8) step();
    pdl_n = 1'b1;
  endtask

  task automatic test_reset();
    int n, pv;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    checks++; if (paddle_pos !== 9'd112) begin errors++; $display("FAIL reset_pos: got %0d expected 112", paddle_pos); end
    checks++; if (pos_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pos_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (pdl_discharge !== 1'b0) begin errors++; $display("FAIL reset_discharge: got %b expected 0", pdl_discharge); end
    frame_rise();
    checks++; if (pos_valid !== 1'b0) begin errors++; $display("FAIL first_frame_no_commit: got %b expected 0", pos_valid); end
    discharge_len(n, pv);
    checks++; if (n !== 8) begin errors++; $display("FAIL discharge_len: got %0d expected 8", n); end
  endtask

  task automatic test_normal();
    int n, pv;
    measure(50);
    repeat (20) step();
    frame_rise();
    model_pos = commit_model(model_pos, 40);
    checks++; if (paddle_pos !== 9'(model_pos)) begin errors++; $display("FAIL normal_pos: got %0d expected %0d", paddle_pos, model_pos); end
    checks++; if (pos_valid !== 1'b1) begin errors++; $display("FAIL normal_valid: got %b expected 1", pos_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL normal_timeout: got %b expected 0", timeout); end
    discharge_len(n, pv);
    checks++; if (pv !== 1) begin errors++; $display("FAIL valid_pulse_len: got %0d expected 1", pv); end
    checks++; if (n !== 8) begin errors++; $display("FAIL normal_discharge_len: got %0d expected 8", n); end
  endtask

  task automatic test_timeout();
    int n, pv;
    repeat (2060) step();
    frame_rise();
    model_pos = commit_model(model_pos, 225);
    checks++; if (paddle_pos !== 9'(model_pos)) begin errors++; $display("FAIL sat_pos: got %0d expected %0d", paddle_pos, model_pos); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL sat_timeout: got %b expected 1", timeout); end
    discharge_len(n, pv);
    measure(30);
    repeat (10) step();
    frame_rise();
    model_pos = commit_model(model_pos, 20);
    checks++; if (paddle_pos !== 9'(model_pos)) begin errors++; $display("FAIL recover_pos: got %0d expected %0d", paddle_pos, model_pos); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL recover_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_underflow_and_discharge_low();
    int n, pv;
    discharge_len(n, pv);
    measure(5);
    repeat (10) step();
    pdl_n = 1'b0;
    frame_rise();
    model_pos = commit_model(model_pos, 0);
    checks++; if (paddle_pos !== 9'(model_pos)) begin errors++; $display("FAIL underflow_pos: got %0d expected %0d", paddle_pos, model_pos); end
    discharge_len(n, pv);
    checks++; if (n !== 8) begin errors++; $display("FAIL low_discharge_len: got %0d expected 8", n); end
    pdl_n = 1'b1;
    measure(60);
    repeat (10) step();
    frame_rise();
    model_pos = commit_model(model_pos, 50);
    checks++; if (paddle_pos !== 9'(model_pos)) begin errors++; $display("FAIL low_ignored_pos: got %0d expected %0d", paddle_pos, model_pos); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL low_ignored_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_abort();
    int n, pv;
    discharge_len(n, pv);
    repeat (40) step();
    frame_rise();
    checks++; if (pos_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", pos_valid); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL abort_timeout: got %b expected 1", timeout); end
    checks++; if (paddle_pos !== 9'(model_pos)) begin errors++; $display("FAIL abort_pos: got %0d expected %0d", paddle_pos, model_pos); end
    checks++; if (pdl_discharge !== 1'b1) begin errors++; $display("FAIL abort_discharge: got %b expected 1", pdl_discharge); end
    discharge_len(n, pv);
    checks++; if (pv !== 0) begin errors++; $display("FAIL abort_no_pulse: got %0d expected 0", pv); end
  endtask

  task automatic test_reset_mid();
    int n, pv;
    repeat (40) step();
    reset = 1'b1;
    #1;
    model_pos = 112;
    checks++; if (paddle_pos !== 9'd112) begin errors++; $display("FAIL midreset_pos: got %0d expected 112", paddle_pos); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL midreset_timeout: got %b expected 0", timeout); end
    checks++; if (pdl_discharge !== 1'b0) begin errors++; $display("FAIL midreset_discharge: got %b expected 0", pdl_discharge); end
    step();
    reset = 1'b0;
    step();
    frame_rise();
    step();
    reset = 1'b1;
    #1;
    checks++; if (pdl_discharge !== 1'b0) begin errors++; $display("FAIL dis_reset_discharge: got %b expected 0", pdl_discharge); end
    step();
    reset = 1'b0;
    step();
    frame_rise();
    checks++; if (pos_valid !== 1'b0) begin errors++; $display("FAIL post_reset_no_commit: got %b expected 0", pos_valid); end
    discharge_len(n, pv);
    checks++; if (n !== 8) begin errors++; $display("FAIL post_reset_discharge_len: got %0d expected 8", n); end
    measure(100);
    repeat (10) step();
    frame_rise();
    model_pos = commit_model(model_pos, 90);
    checks++; if (paddle_pos !== 9'(model_pos)) begin errors++; $display("FAIL post_reset_pos: got %0d expected %0d", paddle_pos, model_pos); end
    checks++; if (pos_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %b expected 1", pos_valid); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_underflow_and_discharge_low();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
